// File: rtl/ecc_pkg.sv
// ECC core shared definitions: AU opcode fields,
// arbiter FSM encoding and default timeout width.
package ecc_pkg;

  // AU opcode [1:0] operation select
  localparam logic [1:0] OP_FA  = 2'b00;
  localparam logic [1:0] OP_MUL = 2'b01;
  localparam logic [1:0] OP_INV = 2'b10;

  // AU opcode bit positions
  localparam int CURVE_X255 = 2;
  localparam int MOD_N      = 3;

  localparam int TMOW_DEF = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } arb_st_e;

endpackage

// File: rtl/au_rr_pick.sv
// 2-way round-robin picker. req: request bits,
// last: last served; idx/vld: chosen requester.
module au_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       idx,
  output logic       vld
);

  always_comb begin
    vld = |req;
    idx = 1'b0;
    unique case (req)
      2'b01:   idx = 1'b0;
      2'b10:   idx = 1'b1;
      2'b11:   idx = ~last;
      default: idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/au_arbiter.sv
// Shares one AU between two sequencers (r0, r1):
// round-robin grant, issue, timed wait, result return.
module au_arbiter
  import ecc_pkg::*;
#(
  parameter int WIDTH = 256,
  parameter int OPWID = 4,
  parameter int TMOW  = TMOW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             r0_req,
  input  logic [WIDTH-1:0] r0_dat1,
  input  logic [WIDTH-1:0] r0_dat2,
  input  logic             r0_carry,
  input  logic [OPWID-1:0] r0_opcode,
  input  logic             r0_swapop,
  input  logic             r0_swapvl,
  output logic             r0_gnt,
  output logic             r0_done,
  output logic             r0_err,
  input  logic             r1_req,
  input  logic [WIDTH-1:0] r1_dat1,
  input  logic [WIDTH-1:0] r1_dat2,
  input  logic             r1_carry,
  input  logic [OPWID-1:0] r1_opcode,
  input  logic             r1_swapop,
  input  logic             r1_swapvl,
  output logic             r1_gnt,
  output logic             r1_done,
  output logic             r1_err,
  output logic [WIDTH-1:0] rslt,
  output logic [WIDTH-1:0] rswap,
  output logic             busy,
  output logic             owner,
  output logic [WIDTH-1:0] au_dat1,
  output logic [WIDTH-1:0] au_dat2,
  output logic             au_carry,
  output logic             au_swapop,
  output logic             au_swapvl,
  output logic [OPWID-1:0] au_opcode,
  output logic             au_start,
  input  logic [WIDTH-1:0] au_rslt,
  input  logic [WIDTH-1:0] au_rswap,
  input  logic             au_vld
);

  arb_st_e          st_q, st_d;
  logic [TMOW-1:0]  cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] rslt_q, rslt_d;
  logic [WIDTH-1:0] rswap_q, rswap_d;
  logic [WIDTH-1:0] dat1_q, dat1_d;
  logic [WIDTH-1:0] dat2_q, dat2_d;
  logic             carry_q, carry_d;
  logic             swapop_q, swapop_d;
  logic             swapvl_q, swapvl_d;
  logic [OPWID-1:0] op_q, op_d;
  logic             pick_idx, pick_vld;

  au_rr_pick u_pick (
    .req  ({r1_req, r0_req}),
    .last (last_q),
    .idx  (pick_idx),
    .vld  (pick_vld)
  );

  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    owner_d  = owner_q;
    rslt_d   = rslt_q;
    rswap_d  = rswap_q;
    dat1_d   = dat1_q;
    dat2_d   = dat2_q;
    carry_d  = carry_q;
    swapop_d = swapop_q;
    swapvl_d = swapvl_q;
    op_d     = op_q;
    unique case (st_q)
      ST_IDLE: begin
        if (pick_vld) begin
          st_d     = ST_ISSUE;
          owner_d  = pick_idx;
          last_d   = pick_idx;
          dat1_d   = pick_idx ? r1_dat1 : r0_dat1;
          dat2_d   = pick_idx ? r1_dat2 : r0_dat2;
          carry_d  = pick_idx ? r1_carry : r0_carry;
          swapop_d = pick_idx ? r1_swapop : r0_swapop;
          swapvl_d = pick_idx ? r1_swapvl : r0_swapvl;
          op_d     = pick_idx ? r1_opcode : r0_opcode;
        end
      end
      ST_ISSUE: begin
        cnt_d = '0;
        st_d  = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + TMOW'(1);
        // a result arriving on the expiry cycle still counts
        if (au_vld) begin
          rslt_d  = au_rslt;
          rswap_d = au_rswap;
          st_d    = ST_DONE;
        end else if (&cnt_d) begin
          st_d = ST_ERR;
        end
      end
      ST_DONE: st_d = ST_IDLE;
      ST_ERR:  st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q     <= ST_IDLE;
      cnt_q    <= '0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      rslt_q   <= '0;
      rswap_q  <= '0;
      dat1_q   <= '0;
      dat2_q   <= '0;
      carry_q  <= 1'b0;
      swapop_q <= 1'b0;
      swapvl_q <= 1'b0;
      op_q     <= '0;
    end else begin
      st_q     <= st_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      rslt_q   <= rslt_d;
      rswap_q  <= rswap_d;
      dat1_q   <= dat1_d;
      dat2_q   <= dat2_d;
      carry_q  <= carry_d;
      swapop_q <= swapop_d;
      swapvl_q <= swapvl_d;
      op_q     <= op_d;
    end
  end

  logic gnt, done, err;

  // pulses are masked in a reset cycle so nothing leaks
  assign gnt  = (st_q == ST_IDLE) && pick_vld && !rst;
  assign done = (st_q == ST_DONE) && !rst;
  assign err  = (st_q == ST_ERR) && !rst;

  assign r0_gnt  = gnt && !pick_idx;
  assign r1_gnt  = gnt && pick_idx;
  assign r0_done = done && !owner_q;
  assign r1_done = done && owner_q;
  assign r0_err  = err && !owner_q;
  assign r1_err  = err && owner_q;

  assign au_start  = (st_q == ST_ISSUE) && !rst;
  assign busy      = (st_q != ST_IDLE);
  assign owner     = owner_q;
  assign rslt      = rslt_q;
  assign rswap     = rswap_q;
  assign au_dat1   = dat1_q;
  assign au_dat2   = dat2_q;
  assign au_carry  = carry_q;
  assign au_swapop = swapop_q;
  assign au_swapvl = swapvl_q;
  assign au_opcode = op_q;

endmodule

// File: tb/tb_au_arbiter.sv
// Bench for au_arbiter: behavioural AU model,
// directed scenarios plus a randomized round-robin model.
module tb_au_arbiter;
  import ecc_pkg::*;

  localparam int W  = 256;
  localparam int OW = 4;
  localparam int TW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          r0_req, r1_req;
  logic [W-1:0]  r0_dat1, r0_dat2, r1_dat1, r1_dat2;
  logic          r0_carry, r1_carry;
  logic [OW-1:0] r0_opcode, r1_opcode;
  logic          r0_swapop, r0_swapvl, r1_swapop, r1_swapvl;
  logic          r0_gnt, r0_done, r0_err;
  logic          r1_gnt, r1_done, r1_err;
  logic [W-1:0]  rslt, rswap;
  logic          busy, owner;
  logic [W-1:0]  au_dat1, au_dat2;
  logic          au_carry, au_swapop, au_swapvl;
  logic [OW-1:0] au_opcode;
  logic          au_start;
  logic [W-1:0]  au_rslt, au_rswap;
  logic          au_vld;

  au_arbiter #(.WIDTH(W), .OPWID(OW), .TMOW(TW)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_dat1(r0_dat1), .r0_dat2(r0_dat2),
    .r0_carry(r0_carry), .r0_opcode(r0_opcode),
    .r0_swapop(r0_swapop), .r0_swapvl(r0_swapvl),
    .r0_gnt(r0_gnt), .r0_done(r0_done), .r0_err(r0_err),
    .r1_req(r1_req), .r1_dat1(r1_dat1), .r1_dat2(r1_dat2),
    .r1_carry(r1_carry), .r1_opcode(r1_opcode),
    .r1_swapop(r1_swapop), .r1_swapvl(r1_swapvl),
    .r1_gnt(r1_gnt), .r1_done(r1_done), .r1_err(r1_err),
    .rslt(rslt), .rswap(rswap), .busy(busy), .owner(owner),
    .au_dat1(au_dat1), .au_dat2(au_dat2), .au_carry(au_carry),
    .au_swapop(au_swapop), .au_swapvl(au_swapvl),
    .au_opcode(au_opcode), .au_start(au_start),
    .au_rslt(au_rslt), .au_rswap(au_rswap), .au_vld(au_vld)
  );

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  // events: 0 g0, 1 g1, 2 d0, 3 d1, 4 e0, 5 e1, 6 start
  int ev_cnt[7];
  int ev_cyc[7];
  int busy_lo = 0;
  int au_lat = 4;
  bit pend = 0;
  int vld_at = 0;
  bit drop0 = 0;
  bit drop1 = 0;
  logic [W-1:0] m_rslt, m_rswap;
  logic [W-1:0] exp_r, exp_s;

  logic [W-1:0]  q_a[2], q_b[2];
  logic          q_c[2], q_so[2], q_sv[2];
  logic [OW-1:0] q_op[2];

  function automatic logic [W-1:0] fn_rslt(
    input logic [OW-1:0] op, input logic [W-1:0] a,
    input logic [W-1:0] b, input logic c);
    case (op[1:0])
      OP_FA:   return a + b + W'(c);
      OP_MUL:  return a * b;
      OP_INV:  return ~a;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [W-1:0] fn_rswap(
    input logic [W-1:0] a, input logic [W-1:0] b,
    input logic so, input logic sv);
    return {a[W/2-1:0], b[W/2-1:0]} ^ W'({so, sv});
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] v = '0;
    for (int i = 0; i < W / 32; i++) v = {v[W-33:0], 32'($urandom())};
    return v;
  endfunction

  function automatic logic sig(input int k);
    case (k)
      0: return r0_gnt;
      1: return r1_gnt;
      2: return r0_done;
      3: return r1_done;
      4: return r0_err;
      5: return r1_err;
      6: return au_start;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag,
                     input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // observe one cycle at negedge, then drive the next
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 7; k++)
      if (sig(k)) begin
        ev_cnt[k]++;
        ev_cyc[k] = cyc;
      end
    if (r0_gnt) drop0 = 1;
    if (r1_gnt) drop1 = 1;
    if (!busy) busy_lo++;
    if (au_start && au_lat >= 0) begin
      pend    = 1;
      vld_at  = cyc + au_lat;
      m_rslt  = fn_rslt(au_opcode, au_dat1, au_dat2, au_carry);
      m_rswap = fn_rswap(au_dat1, au_dat2, au_swapop, au_swapvl);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (drop0) begin r0_req = 0; drop0 = 0; end
    if (drop1) begin r1_req = 0; drop1 = 0; end
    au_vld = pend && (cyc == vld_at);
    if (au_vld) begin
      pend     = 0;
      au_rslt  = m_rslt;
      au_rswap = m_rswap;
    end
  endtask

  task automatic run_until(input int k, input int lim, output int at);
    int c0 = ev_cnt[k];
    at = -1;
    for (int i = 0; i < lim; i++) begin
      tick();
      if (ev_cnt[k] != c0) begin
        at = ev_cyc[k];
        break;
      end
    end
  endtask

  task automatic drive(input int n, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic c,
                       input logic [OW-1:0] op,
                       input logic so, input logic sv);
    q_a[n] = a; q_b[n] = b; q_c[n] = c;
    q_op[n] = op; q_so[n] = so; q_sv[n] = sv;
    if (n == 0) begin
      r0_dat1 = a; r0_dat2 = b; r0_carry = c;
      r0_opcode = op; r0_swapop = so; r0_swapvl = sv;
      r0_req = 1;
    end else begin
      r1_dat1 = a; r1_dat2 = b; r1_carry = c;
      r1_opcode = op; r1_swapop = so; r1_swapvl = sv;
      r1_req = 1;
    end
  endtask

  task automatic drive_rnd(input int n);
    drive(n, rnd(), rnd(), 1'($urandom()), 4'($urandom()),
          1'($urandom()), 1'($urandom()));
  endtask

  task automatic set_exp(input int n);
    exp_r = fn_rslt(q_op[n], q_a[n], q_b[n], q_c[n]);
    exp_s = fn_rswap(q_a[n], q_b[n], q_so[n], q_sv[n]);
  endtask

  task automatic do_reset(input bit clr_au);
    rst = 1; r0_req = 0; r1_req = 0; au_vld = 0;
    drop0 = 0; drop1 = 0;
    if (clr_au) pend = 0;
    tick();
    tick();
    rst = 0;
    exp_r = '0;
    exp_s = '0;
  endtask

  initial begin
    int t0, at, s, dn, c0, c1, c2, win;
    bit [1:0] pm;
    bit last_m;
    for (int k = 0; k < 7; k++) begin
      ev_cnt[k] = 0;
      ev_cyc[k] = 0;
    end
    rst = 1; au_vld = 0; au_rslt = '0; au_rswap = '0;
    r0_req = 0; r1_req = 0;
    drive(0, '0, '0, 0, '0, 0, 0);
    drive(1, '0, '0, 0, '0, 0, 0);
    r0_req = 0; r1_req = 0;
    do_reset(1);

    chk("rst_ctl", W'({r0_gnt, r1_gnt, r0_done, r1_done, r0_err,
        r1_err, busy, owner, au_start, au_carry, au_swapop,
        au_swapvl, au_opcode}), '0);
    chk("rst_rslt", rslt | rswap, '0);
    chk("rst_audat", au_dat1 | au_dat2, '0);

    // single r0 multiply 3*5
    au_lat = 4;
    c1 = ev_cnt[1] + ev_cnt[3] + ev_cnt[5];
    drive(0, W'(3), W'(5), 0, 4'b0001, 0, 0);
    t0 = cyc;
    run_until(0, 3, at);  chk("t1_gnt", W'(at), W'(t0));
    run_until(6, 3, at);  chk("t1_start", W'(at), W'(t0 + 1));
    run_until(2, 20, at); chk("t1_done", W'(at), W'(t0 + 6));
    chk("t1_rslt", rslt, W'(15));
    chk("t1_rswap", rswap, fn_rswap(W'(3), W'(5), 0, 0));
    chk("t1_r1_quiet", W'(ev_cnt[1] + ev_cnt[3] + ev_cnt[5]), W'(c1));

    // simultaneous pairs after reset
    do_reset(1);
    au_lat = $urandom_range(1, 13);
    drive_rnd(0);
    drive_rnd(1);
    t0 = cyc;
    c1 = ev_cnt[1];
    run_until(0, 3, at); chk("t2_gnt0", W'(at), W'(t0));
    chk("t2_no_g1", W'(ev_cnt[1]), W'(c1));
    run_until(2, 30, dn); chk("t2_done0", W'(dn), W'(t0 + 2 + au_lat));
    set_exp(0);
    chk("t2_rslt0", rslt, exp_r);
    run_until(1, 3, at); chk("t2_gnt1", W'(at), W'(dn + 1));
    run_until(3, 30, dn); chk("t2_done1", W'(dn), W'(at + 2 + au_lat));
    set_exp(1);
    chk("t2_rswap1", rswap, exp_s);
    drive_rnd(0);
    drive_rnd(1);
    t0 = cyc;
    run_until(0, 3, at); chk("t2_gnt0_again", W'(at), W'(t0));

    // r1 arrives while r0 waits
    do_reset(1);
    au_lat = 8;
    drive_rnd(0);
    run_until(6, 3, s);
    drive_rnd(1);
    c1 = ev_cnt[1];
    c0 = busy_lo;
    run_until(2, 30, dn); chk("t3_done0", W'(dn), W'(s + 1 + au_lat));
    chk("t3_no_early_g1", W'(ev_cnt[1]), W'(c1));
    chk("t3_busy", W'(busy_lo), W'(c0));
    run_until(1, 3, at); chk("t3_gnt1", W'(at), W'(dn + 1));
    run_until(3, 30, dn);
    set_exp(1);
    chk("t3_rslt1", rslt, exp_r);

    // timeout, then a late stray au_vld
    au_lat = -1;
    drive_rnd(0);
    c0 = ev_cnt[2];
    run_until(6, 3, s);
    run_until(4, 40, at); chk("t4_err", W'(at), W'(s + 16));
    chk("t4_no_done", W'(ev_cnt[2]), W'(c0));
    chk("t4_rslt_hold", rslt, exp_r);
    au_vld = 1;
    au_rslt = rnd();
    au_rswap = rnd();
    tick();
    tick();
    chk("t4_stray_done", W'(ev_cnt[2] + ev_cnt[3]), W'(c0 + ev_cnt[3]));
    chk("t4_idle", W'(busy), W'(0));
    chk("t4_rslt_stray", rslt, exp_r);
    chk("t4_rswap_stray", rswap, exp_s);

    // au_vld on the expiry cycle
    au_lat = 15;
    drive_rnd(0);
    c2 = ev_cnt[4];
    run_until(6, 3, s);
    run_until(2, 30, at); chk("t6_done", W'(at), W'(s + 16));
    chk("t6_no_err", W'(ev_cnt[4]), W'(c2));
    set_exp(0);
    chk("t6_rslt", rslt, exp_r);

    // reset while r1 waits
    au_lat = 6;
    drive_rnd(1);
    run_until(6, 3, s);
    tick();
    c0 = ev_cnt[2] + ev_cnt[3] + ev_cnt[4] + ev_cnt[5];
    rst = 1;
    tick();
    rst = 0;
    exp_r = '0;
    chk("t5_ctl", W'({r0_gnt, r1_gnt, r0_done, r1_done, r0_err,
        r1_err, busy, owner, au_start, au_carry, au_swapop,
        au_swapvl, au_opcode}), '0);
    chk("t5_rslt", rslt | rswap | au_dat1 | au_dat2, '0);
    for (int i = 0; i < 8; i++) tick();
    chk("t5_stray", W'(ev_cnt[2] + ev_cnt[3] + ev_cnt[4] + ev_cnt[5]),
        W'(c0));
    chk("t5_rslt_kept", rslt, '0);
    drive_rnd(1);
    t0 = cyc;
    run_until(1, 3, at); chk("t5_gnt1", W'(at), W'(t0));
    chk("t5_owner", W'(owner), W'(1));
    run_until(3, 30, at); chk("t5_done1", W'(at), W'(t0 + 2 + au_lat));
    set_exp(1);
    chk("t5_rslt1", rslt, exp_r);

    // randomized traffic against a round-robin model
    do_reset(1);
    last_m = 1;
    pm = 2'b00;
    for (int it = 0; it < 24; it++) begin
      for (int n = 0; n < 2; n++)
        if (!pm[n] && $urandom_range(0, 1) == 1) begin
          drive_rnd(n);
          pm[n] = 1;
        end
      if (pm == 2'b00) begin
        win = $urandom_range(0, 1);
        drive_rnd(win);
        pm[win] = 1;
      end
      au_lat = $urandom_range(1, 13);
      win = (pm == 2'b11) ? int'(!last_m) : int'(pm[1]);
      t0 = cyc;
      c1 = ev_cnt[1 - win];
      run_until(win, 3, at); chk("rnd_gnt", W'(at), W'(t0));
      chk("rnd_owner", W'(owner), W'(win));
      chk("rnd_other", W'(ev_cnt[1 - win]), W'(c1));
      run_until(2 + win, 30, at);
      chk("rnd_done", W'(at), W'(t0 + 2 + au_lat));
      set_exp(win);
      chk("rnd_rslt", rslt, exp_r);
      chk("rnd_rswap", rswap, exp_s);
      pm[win] = 0;
      last_m = 1'(win);
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
